// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: grant identity, latched operation
// and the round-robin pick rule used in IDLE.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {arb_none, arb_i, arb_d} lc3b_arb_grant;
  typedef enum logic {arb_rd, arb_wr} lc3b_arb_op;

  // A tie goes to whichever requester was not served last.
  function automatic lc3b_arb_grant arb_pick(input logic          i_req,
                                             input logic          d_req,
                                             input lc3b_arb_grant last);
    lc3b_arb_grant g;
    g = arb_none;
    if (i_req && d_req) g = (last == arb_i) ? arb_d : arb_i;
    else if (i_req)     g = arb_i;
    else if (d_req)     g = arb_d;
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Grant watchdog: counts cycles spent in a grant and flags the cycle in which
// the grant has lasted TIMEOUT cycles. TIMEOUT of 0 disables it.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q holds the number of completed grant cycles, so TIMEOUT-1 marks the
  // TIMEOUT-th cycle of the grant.
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between instruction fetch (I) and data (D)
// requesters with round-robin arbitration and a grant watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MASK_W  = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [MASK_W-1:0] d_byte_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [MASK_W-1:0] pmem_byte_en,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

  state_t            state_q;
  lc3b_arb_grant     last_q;
  lc3b_arb_op        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] ben_q;
  logic              err_q;

  lc3b_arb_grant pick;
  logic          in_gnt;
  logic          wd_clear;
  logic          wd_expired;
  logic          abort;
  logic          finish;

  assign pick     = arb_pick(i_read, d_read | d_write, last_q);
  assign in_gnt   = (state_q == GNT_I) || (state_q == GNT_D);
  assign wd_clear = (state_q == IDLE) && (pick != arb_none);
  assign abort    = in_gnt && !pmem_resp && wd_expired;
  assign finish   = in_gnt && (pmem_resp || wd_expired);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (in_gnt),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= arb_d;
      op_q    <= arb_rd;
      addr_q  <= '0;
      wdata_q <= '0;
      ben_q   <= '1;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          case (pick)
            arb_i: begin
              state_q <= GNT_I;
              last_q  <= arb_i;
              op_q    <= arb_rd;
              addr_q  <= i_addr;
              wdata_q <= '0;
              ben_q   <= '1;
            end
            arb_d: begin
              state_q <= GNT_D;
              last_q  <= arb_d;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              // A write wins when the data side raises both strobes.
              if (d_write) begin
                op_q  <= arb_wr;
                ben_q <= d_byte_en;
              end else begin
                op_q  <= arb_rd;
                ben_q <= '1;
              end
            end
            default: ;
          endcase
        end
        GNT_I, GNT_D: begin
          if (finish) state_q <= DONE;
          if (abort)  err_q   <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes decode only state and latched op, so an async reset drops them at once.
  assign pmem_read    = in_gnt && (op_q == arb_rd);
  assign pmem_write   = in_gnt && (op_q == arb_wr);
  assign pmem_byte_en = ben_q;
  assign pmem_addr    = addr_q;
  assign pmem_wdata   = wdata_q;
  assign arb_err      = err_q;

  assign i_resp  = (state_q == GNT_I) && finish;
  assign d_resp  = (state_q == GNT_D) && finish;
  assign i_rdata = ((state_q == GNT_I) && pmem_resp) ? pmem_rdata : '0;
  assign d_rdata = ((state_q == GNT_D) && pmem_resp) ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, multi-cycle corner sequences
// and a randomized run against a transaction-level memory/round-robin model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_read, d_read, d_write, pmem_resp;
  logic [15:0] i_addr, d_addr, d_wdata, pmem_rdata;
  logic [1:0]  d_byte_en;
  logic [15:0] i_rdata, d_rdata, pmem_addr, pmem_wdata;
  logic        i_resp, d_resp, pmem_read, pmem_write, arb_err;
  logic [1:0]  pmem_byte_en;

  int compared   = 0;
  int mismatched = 0;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MASK_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_en(d_byte_en), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_byte_en(pmem_byte_en),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  ben;
    int unsigned lat;
    logic [15:0] rdata;
    logic        exp_rd;
    logic        exp_wr;
    logic [1:0]  exp_ben;
  } vec_t;

  vec_t tv[6];

  logic [15:0] devmem[16];
  logic [15:0] refmem[16];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drop_reqs();
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int          w;
    logic        found;
    logic [15:0] exp_a;
    logic [3:0]  i_a, d_a;
    logic        i_pend, d_pend, d_wr, d_rb, strobe;
    logic        prev_i, prev_d, prev_strobe, prev_resp;
    logic [15:0] d_wd;
    logic [1:0]  d_be;
    int          i_gap, d_gap, owner, rm_last, win, n_i, n_d;
    int unsigned lat;

    tv[0] = '{is_d:1'b0, rd:1'b1, wr:1'b0, addr:16'h0040, wdata:16'h0000, ben:2'b00, lat:2,
              rdata:16'h1234, exp_rd:1'b1, exp_wr:1'b0, exp_ben:2'b11};
    tv[1] = '{is_d:1'b1, rd:1'b0, wr:1'b1, addr:16'h0101, wdata:16'hAB00, ben:2'b10, lat:2,
              rdata:16'h0F0F, exp_rd:1'b0, exp_wr:1'b1, exp_ben:2'b10};
    tv[2] = '{is_d:1'b1, rd:1'b1, wr:1'b0, addr:16'h2222, wdata:16'h9999, ben:2'b01, lat:0,
              rdata:16'h5A5A, exp_rd:1'b1, exp_wr:1'b0, exp_ben:2'b11};
    tv[3] = '{is_d:1'b1, rd:1'b1, wr:1'b1, addr:16'hFFFF, wdata:16'h00FF, ben:2'b01, lat:1,
              rdata:16'h3C3C, exp_rd:1'b0, exp_wr:1'b1, exp_ben:2'b01};
    tv[4] = '{is_d:1'b0, rd:1'b1, wr:1'b0, addr:16'h0000, wdata:16'h0000, ben:2'b00, lat:0,
              rdata:16'hFFFF, exp_rd:1'b1, exp_wr:1'b0, exp_ben:2'b11};
    tv[5] = '{is_d:1'b1, rd:1'b0, wr:1'b1, addr:16'h8000, wdata:16'hC3C3, ben:2'b11, lat:3,
              rdata:16'h7E7E, exp_rd:1'b0, exp_wr:1'b1, exp_ben:2'b11};

    drop_reqs();
    i_addr = '0; d_addr = '0; d_wdata = '0; d_byte_en = '0;
    pmem_resp = 1'b1; pmem_rdata = 16'hBAD0;

    // Reset state, with a stray pmem_resp that must not produce a response.
    tick(); tick(); #1;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_byte_en", pmem_byte_en, 2'b11);
    chk("rst_addr", pmem_addr, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_arb_err", arb_err, 0);
    chk("rst_resp", {i_resp, d_resp}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    tick(); rst = 1'b0; pmem_resp = 1'b0;

    // Simultaneous I and D out of reset: I first, then D after DONE + one IDLE cycle.
    tick(); i_read = 1'b1; i_addr = 16'h0123; d_read = 1'b1; d_addr = 16'h0456; #1;
    chk("t2_idle_strobe", pmem_read | pmem_write, 0);
    tick(); pmem_resp = 1'b1; pmem_rdata = 16'h1111; #1;
    chk("t2_first_read", pmem_read, 1);
    chk("t2_first_addr", pmem_addr, 16'h0123);
    chk("t2_i_resp", i_resp, 1);
    chk("t2_i_rdata", i_rdata, 16'h1111);
    chk("t2_d_resp_held", d_resp, 0);
    chk("t2_d_rdata_zero", d_rdata, 0);
    tick(); pmem_resp = 1'b0; i_read = 1'b0; #1;
    chk("t2_done_strobe", pmem_read | pmem_write, 0);
    tick(); #1;
    chk("t2_idle2_strobe", pmem_read | pmem_write, 0);
    tick(); #1;
    chk("t2_second_read", pmem_read, 1);
    chk("t2_second_addr", pmem_addr, 16'h0456);
    pmem_resp = 1'b1; pmem_rdata = 16'h2222; #1;
    chk("t2_d_resp", d_resp, 1);
    chk("t2_d_rdata", d_rdata, 16'h2222);
    chk("t2_i_resp_quiet", i_resp, 0);
    tick(); pmem_resp = 1'b0; d_read = 1'b0;
    tick();

    // Continuous I and D requests: I, then strictly alternating D, I, ...
    i_read = 1'b1; i_addr = 16'h0AAA; d_read = 1'b1; d_addr = 16'h0DDD; d_write = 1'b0;
    for (int g = 0; g < 7; g++) begin
      found = 1'b0;
      w = 0;
      while (!found && w < 6) begin
        tick(); pmem_resp = 1'b0; #1;
        if (pmem_read) found = 1'b1;
        else w++;
      end
      chk("t4_found", found, 1);
      if (!found) break;
      chk("t4_gap", w, (g == 0) ? 0 : 2);
      exp_a = (g % 2 == 0) ? 16'h0AAA : 16'h0DDD;
      chk("t4_addr", pmem_addr, exp_a);
      pmem_resp = 1'b1; pmem_rdata = 16'h1000 + 16'(g); #1;
      chk("t4_i_resp", i_resp, (g % 2 == 0));
      chk("t4_d_resp", d_resp, (g % 2 == 1));
    end
    tick(); pmem_resp = 1'b0; drop_reqs();
    tick();

    // Table-driven single transactions; stray pmem_resp in DONE and IDLE must be ignored.
    for (int t = 0; t < 6; t++) begin
      tick();
      if (tv[t].is_d) begin
        d_read = tv[t].rd; d_write = tv[t].wr; d_addr = tv[t].addr;
        d_wdata = tv[t].wdata; d_byte_en = tv[t].ben;
      end else begin
        i_read = 1'b1; i_addr = tv[t].addr;
        d_wdata = 16'h5555; d_byte_en = 2'b01;
      end
      pmem_resp = 1'b0; #1;
      chk("tv_idle_strobe", pmem_read | pmem_write, 0);
      for (int unsigned k = 0; k <= tv[t].lat; k++) begin
        tick();
        pmem_resp  = (k == tv[t].lat);
        pmem_rdata = (k == tv[t].lat) ? tv[t].rdata : 16'hDEAD;
        #1;
        chk("tv_read", pmem_read, tv[t].exp_rd);
        chk("tv_write", pmem_write, tv[t].exp_wr);
        chk("tv_addr", pmem_addr, tv[t].addr);
        chk("tv_byte_en", pmem_byte_en, tv[t].exp_ben);
        if (tv[t].exp_wr) chk("tv_wdata", pmem_wdata, tv[t].wdata);
        chk("tv_resp", tv[t].is_d ? d_resp : i_resp, (k == tv[t].lat));
        chk("tv_other_resp", tv[t].is_d ? i_resp : d_resp, 0);
        chk("tv_other_rdata", tv[t].is_d ? i_rdata : d_rdata, 0);
        if (k == tv[t].lat) chk("tv_rdata", tv[t].is_d ? d_rdata : i_rdata, tv[t].rdata);
      end
      tick(); drop_reqs(); pmem_resp = 1'b1; #1;
      chk("tv_done_strobe", pmem_read | pmem_write, 0);
      chk("tv_done_resp", i_resp | d_resp, 0);
      tick(); #1;
      chk("tv_idle_resp", i_resp | d_resp, 0);
      pmem_resp = 1'b0;
    end

    // Watchdog: D read never answered aborts in grant cycle 8; arb_err sticks.
    tick(); d_read = 1'b1; d_write = 1'b0; d_addr = 16'h0777; pmem_rdata = 16'hFFFF; #1;
    for (int k = 1; k <= 8; k++) begin
      tick(); #1;
      chk("t5_read", pmem_read, 1);
      chk("t5_d_resp", d_resp, (k == 8));
      chk("t5_err_pending", arb_err, 0);
      if (k == 8) chk("t5_d_rdata", d_rdata, 0);
    end
    tick(); d_read = 1'b0; #1;
    chk("t5_err_set", arb_err, 1);
    chk("t5_done_strobe", pmem_read, 0);
    chk("t5_done_resp", d_resp, 0);
    tick(); i_read = 1'b1; i_addr = 16'h0010; #1;
    tick(); #1;
    chk("t5_i_read", pmem_read, 1);
    chk("t5_i_addr", pmem_addr, 16'h0010);
    pmem_resp = 1'b1; pmem_rdata = 16'hBEEF; #1;
    chk("t5_i_resp", i_resp, 1);
    chk("t5_i_rdata", i_rdata, 16'hBEEF);
    tick(); i_read = 1'b0; pmem_resp = 1'b0; #1;
    chk("t5_err_sticky", arb_err, 1);
    tick();

    // Reset two cycles into an I grant: strobe drops at once, request re-served afterwards.
    tick(); i_read = 1'b1; i_addr = 16'h0300; #1;
    tick(); #1;
    chk("t6_grant1", pmem_read, 1);
    tick(); rst = 1'b1; pmem_resp = 1'b1; pmem_rdata = 16'h4444; #1;
    chk("t6_rst_read", pmem_read, 0);
    chk("t6_rst_resp", i_resp, 0);
    chk("t6_rst_err", arb_err, 0);
    chk("t6_rst_addr", pmem_addr, 0);
    tick(); rst = 1'b0; pmem_resp = 1'b0; #1;
    chk("t6_idle_read", pmem_read, 0);
    tick(); #1;
    chk("t6_reissue_read", pmem_read, 1);
    chk("t6_reissue_addr", pmem_addr, 16'h0300);
    pmem_resp = 1'b1; pmem_rdata = 16'h7777; #1;
    chk("t6_i_resp", i_resp, 1);
    chk("t6_i_rdata", i_rdata, 16'h7777);
    tick(); i_read = 1'b0; pmem_resp = 1'b0;
    tick();

    // Randomized traffic against a memory model and the round-robin rule.
    for (int i = 0; i < 16; i++) begin
      devmem[i] = 16'($urandom);
      refmem[i] = devmem[i];
    end
    i_pend = 1'b0; d_pend = 1'b0; i_gap = 0; d_gap = 1;
    i_a = '0; d_a = '0; d_wr = 1'b0; d_rb = 1'b0; d_wd = '0; d_be = 2'b11;
    prev_i = 1'b0; prev_d = 1'b0; prev_strobe = 1'b0; prev_resp = 1'b0;
    owner = 0; rm_last = 1; lat = 0; n_i = 0; n_d = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick();
      if (!i_pend) begin
        if (i_gap == 0) begin i_pend = 1'b1; i_a = 4'($urandom); end
        else i_gap--;
      end
      if (!d_pend) begin
        if (d_gap == 0) begin
          d_pend = 1'b1; d_a = 4'($urandom); d_wr = 1'($urandom_range(0, 1));
          d_rb = 1'($urandom_range(0, 1)); d_wd = 16'($urandom);
          d_be = 2'($urandom_range(1, 3));
        end else d_gap--;
      end
      i_read = i_pend; i_addr = {12'h000, i_a};
      d_write = d_pend && d_wr; d_read = d_pend && (!d_wr || d_rb);
      d_addr = {12'h000, d_a}; d_wdata = d_wd; d_byte_en = d_be;

      strobe = pmem_read | pmem_write;
      if (strobe && !prev_strobe) begin
        if (prev_i && prev_d) win = (rm_last == 1) ? 2 : 1;
        else if (prev_i)      win = 1;
        else if (prev_d)      win = 2;
        else                  win = 0;
        if (win == 0) chk("rnd_spurious_grant", strobe, 0);
        if (win == 1) begin
          chk("rnd_i_access", {pmem_read, pmem_write, pmem_byte_en, pmem_addr},
              {1'b1, 1'b0, 2'b11, 12'h000, i_a});
        end
        if (win == 2) begin
          chk("rnd_d_access", {pmem_read, pmem_write, pmem_byte_en, pmem_addr},
              {!d_wr, d_wr, d_wr ? d_be : 2'b11, 12'h000, d_a});
          if (d_wr) chk("rnd_d_wdata", pmem_wdata, d_wd);
        end
        owner = win;
        if (win != 0) rm_last = win;
        lat = $urandom_range(0, 3);
      end
      pmem_resp = strobe && (lat == 0);
      if (strobe && lat != 0) lat--;
      pmem_rdata = (pmem_resp && pmem_read) ? devmem[pmem_addr[3:0]] : 16'($urandom);
      #1;
      if (prev_resp) chk("rnd_gap", strobe, 0);
      chk("rnd_i_resp", i_resp, pmem_resp && owner == 1);
      chk("rnd_d_resp", d_resp, pmem_resp && owner == 2);
      if (pmem_resp) begin
        if (owner == 1) begin
          chk("rnd_i_rdata", i_rdata, refmem[i_a]);
          chk("rnd_d_rdata_quiet", d_rdata, 0);
          i_pend = 1'b0; i_gap = $urandom_range(0, 2); n_i++;
        end
        if (owner == 2) begin
          if (!d_wr) chk("rnd_d_rdata", d_rdata, refmem[d_a]);
          else       refmem[d_a] = merge(refmem[d_a], d_wd, d_be);
          chk("rnd_i_rdata_quiet", i_rdata, 0);
          d_pend = 1'b0; d_gap = $urandom_range(0, 2); n_d++;
        end
        if (pmem_write)
          devmem[pmem_addr[3:0]] = merge(devmem[pmem_addr[3:0]], pmem_wdata, pmem_byte_en);
        owner = 0;
      end
      prev_i = i_read; prev_d = d_read | d_write;
      prev_strobe = strobe; prev_resp = pmem_resp;
    end
    chk("rnd_i_progress", (n_i >= 20), 1);
    chk("rnd_d_progress", (n_d >= 20), 1);
    chk("rnd_no_err", arb_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
